// File: rtl/feeder_pkg.sv
// Shared constants, FSM state type and lane helper for the systolic array feeder.
package feeder_pkg;
    localparam int N         = 8;
    localparam int DATA_W    = 8;
    localparam int IN_ADDR_W = 12;
    localparam int WT_ADDR_W = 11;
    localparam int K_W       = 12;
    localparam int LANE_W    = N * DATA_W;
    localparam int DRAIN_LEN = N;
    localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    function automatic logic [DATA_W-1:0] lane_byte(input logic [LANE_W-1:0] word, input int lane);
        return word[lane*DATA_W +: DATA_W];
    endfunction
endpackage

// File: rtl/systolic_feeder_skew.sv
// Per-lane delay line: lane i presents byte i of each incoming word i cycles after lane 0.
module skew_line
    import feeder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              in_valid,
    input  logic [LANE_W-1:0] din,
    output logic [LANE_W-1:0] dout,
    output logic [N-1:0]      valid
);
    for (genvar i = 0; i < N; i++) begin : g_lane
        // Stage 0 captures the BRAM word; stages 1..i provide the lane's skew.
        logic [DATA_W-1:0] data_q [0:i];
        logic [i:0]        vld_q;

        // NOTE: these are plain shift registers, not a RAM, so resetting them is cheap
        // and guarantees zero padding on the array edge right after reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k <= i; k++) data_q[k] <= '0;
                vld_q <= '0;
            end else if (!hold) begin
                data_q[0] <= in_valid ? lane_byte(din, i) : '0;
                vld_q[0]  <= in_valid;
                for (int k = 1; k <= i; k++) begin
                    data_q[k] <= data_q[k-1];
                    vld_q[k]  <= vld_q[k-1];
                end
            end
        end

        assign dout[i*DATA_W +: DATA_W] = data_q[i];
        assign valid[i]                 = vld_q[i];
    end
endmodule

// File: rtl/systolic_feeder.sv
// Tile read sequencer: issues BRAM addresses for both operand streams and feeds the skew lines.
module systolic_feeder
    import feeder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [K_W-1:0]       k_len,
    input  logic [IN_ADDR_W-1:0] in_base,
    input  logic [WT_ADDR_W-1:0] wt_base,
    input  logic                 hold,
    output logic                 in_ena,
    output logic                 wt_ena,
    output logic [IN_ADDR_W-1:0] in_addr,
    output logic [WT_ADDR_W-1:0] wt_addr,
    input  logic [LANE_W-1:0]    in_douta,
    input  logic [LANE_W-1:0]    wt_douta,
    output logic [LANE_W-1:0]    a_out,
    output logic [LANE_W-1:0]    b_out,
    output logic [N-1:0]         a_valid,
    output logic [N-1:0]         b_valid,
    output logic                 busy,
    output logic                 done
);
    state_t               state_q, state_d;
    logic [K_W-1:0]       k_len_q;
    logic [K_W-1:0]       word_q;
    logic [IN_ADDR_W-1:0] in_addr_q;
    logic [WT_ADDR_W-1:0] wt_addr_q;
    logic [DRAIN_W-1:0]   drain_q;
    logic                 rd_valid_q;

    logic accept;
    logic last_read;
    logic drain_end;

    assign accept    = (state_q == IDLE) && start && !hold;
    assign last_read = (word_q == k_len_q - K_W'(1));
    assign drain_end = (drain_q == DRAIN_W'(DRAIN_LEN));

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_len_q    <= '0;
            word_q     <= '0;
            in_addr_q  <= '0;
            wt_addr_q  <= '0;
            drain_q    <= '0;
            rd_valid_q <= 1'b0;
        end else if (!hold) begin
            state_q    <= state_d;
            rd_valid_q <= (state_q == READ);
            drain_q    <= (state_q == DRAIN) ? drain_q + DRAIN_W'(1) : '0;
            if (accept) begin
                k_len_q   <= k_len;
                in_addr_q <= in_base;
                wt_addr_q <= wt_base;
                word_q    <= '0;
            end else if (state_q == READ) begin
                // Address counters wrap naturally at their own width.
                in_addr_q <= in_addr_q + IN_ADDR_W'(1);
                wt_addr_q <= wt_addr_q + WT_ADDR_W'(1);
                word_q    <= word_q + K_W'(1);
            end
        end
    end

    // NOTE: next-state logic assigns a default first so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept) state_d = (k_len == '0) ? DONE : READ;
            READ:  if (last_read) state_d = DRAIN;
            DRAIN: if (drain_end) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A held cycle must not issue a read nor count as the done cycle.
    always_comb begin
        in_ena = (state_q == READ) && !hold;
        wt_ena = (state_q == READ) && !hold;
        busy   = (state_q == READ) || (state_q == DRAIN);
        done   = (state_q == DONE) && !hold;
    end

    assign in_addr = in_addr_q;
    assign wt_addr = wt_addr_q;

    skew_line u_skew_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (hold),
        .in_valid (rd_valid_q),
        .din      (in_douta),
        .dout     (a_out),
        .valid    (a_valid)
    );

    skew_line u_skew_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (hold),
        .in_valid (rd_valid_q),
        .din      (wt_douta),
        .dout     (b_out),
        .valid    (b_valid)
    );
endmodule
